hdmi_audio_fifo: RTL and testbench



---
 rtl/hdmi_audio_fifo_pkg.sv | 14 +
 rtl/hdmi_audio_fifo.sv | 114 +++++++++++
 tb/tb_hdmi_audio_fifo.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_audio_fifo_pkg.sv
// Shared definitions for the HDMI stereo PCM elastic buffer: state encoding and
// default geometry.
package hdmi_audio_fifo_pkg;

  localparam int unsigned AF_DEPTH_LOG2 = 3;
  localparam int unsigned AF_WIDTH      = 16;

  typedef enum logic [1:0] {
    AF_IDLE  = 2'd0,
    AF_PRIME = 2'd1,
    AF_RUN   = 2'd2
  } af_state_e;

endpackage

// File: rtl/hdmi_audio_fifo.sv
// Stereo PCM elastic buffer feeding the HDMI encoder audio inputs; primes to half
// full, pops one entry per encoder sample strobe, mutes on disable.
module hdmi_audio_fifo
  import hdmi_audio_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = AF_DEPTH_LOG2,
  parameter int unsigned WIDTH      = AF_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic                  i_in_valid,
  input  logic [WIDTH-1:0]      i_in_l,
  input  logic [WIDTH-1:0]      i_in_r,
  input  logic                  i_sample_req,
  output logic [WIDTH-1:0]      o_out_l,
  output logic [WIDTH-1:0]      o_out_r,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_underrun,
  output logic                  o_overflow
);

  localparam int unsigned Depth   = 1 << DEPTH_LOG2;
  localparam int unsigned Half    = Depth / 2;
  localparam int unsigned LvlW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] LvlFull = LvlW'(Depth);
  localparam logic [DEPTH_LOG2:0] LvlHalf = LvlW'(Half);

  af_state_e               r_state;
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_level;
  logic [WIDTH-1:0]        r_out_l;
  logic [WIDTH-1:0]        r_out_r;
  logic                    r_underrun;
  logic                    r_overflow;
  logic [2*WIDTH-1:0]      r_mem [Depth];

  logic                    w_run;
  logic                    w_prime;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic [DEPTH_LOG2:0]     w_level_next;
  logic [2*WIDTH-1:0]      w_head;

  always_comb begin
    w_run        = (r_state == AF_RUN);
    w_prime      = (r_state == AF_PRIME);
    w_empty      = (r_level == '0);
    w_full       = (r_level == LvlFull);
    w_pop        = w_run && i_sample_req && !w_empty;
    // A push into a full FIFO is legal only when a pop frees the slot this cycle.
    w_push       = (w_run || w_prime) && i_in_valid && (!w_full || w_pop);
    w_level_next = r_level + LvlW'(w_push) - LvlW'(w_pop);
    w_head       = r_mem[r_rd_ptr];
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_in_l, i_in_r};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || !i_enable) begin
      r_state    <= AF_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_out_l    <= '0;
      r_out_r    <= '0;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        AF_IDLE: begin
          r_state    <= AF_PRIME;
          r_underrun <= 1'b0;
          r_overflow <= 1'b0;
        end
        default: begin
          if (w_push) begin
            r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            r_out_l  <= w_head[2*WIDTH-1:WIDTH];
            r_out_r  <= w_head[WIDTH-1:0];
          end else if (w_prime && i_sample_req) begin
            r_out_l  <= '0;
            r_out_r  <= '0;
          end
          r_level    <= w_level_next;
          r_overflow <= i_in_valid && w_full && !w_pop;
          r_underrun <= w_run && i_sample_req && w_empty;
          if (w_prime && (w_level_next >= LvlHalf)) begin
            r_state <= AF_RUN;
          end else if (w_run && i_sample_req && w_empty) begin
            r_state <= AF_PRIME;
          end
        end
      endcase
    end
  end

  assign o_out_l    = r_out_l;
  assign o_out_r    = r_out_r;
  assign o_level    = r_level;
  assign o_underrun = r_underrun;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_hdmi_audio_fifo.sv
// Directed scoreboard bench for hdmi_audio_fifo: expected pops and per-cycle status
// are queued by the stimulus and checked by an independent monitor.
module tb_hdmi_audio_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        v;
  logic        req;
  logic [15:0] il;
  logic [15:0] ir;
  logic [15:0] ol;
  logic [15:0] orr;
  logic [3:0]  lvl;
  logic        uf;
  logic        of;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  typedef struct {
    int lvl;
    bit uf;
    bit of;
    bit z;
  } stat_t;

  pair_t data_q[$];
  stat_t stat_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  logic  req_d       = 1'b0;

  always #5 clk = ~clk;

  hdmi_audio_fifo #(
    .DEPTH_LOG2(3),
    .WIDTH     (16)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_enable    (en),
    .i_in_valid  (v),
    .i_in_l      (il),
    .i_in_r      (ir),
    .i_sample_req(req),
    .o_out_l     (ol),
    .o_out_r     (orr),
    .o_level     (lvl),
    .o_underrun  (uf),
    .o_overflow  (of)
  );

  // A request seen at an edge while running must be reflected on the outputs after it.
  always @(posedge clk) req_d <= req && rst_n && en;

  always @(negedge clk) begin
    stat_t s;
    pair_t p;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      vectors++;
      if (lvl !== 4'(s.lvl) || uf !== s.uf || of !== s.of) begin
        miscompares++;
        $display("FAIL status @%0t: level=%0d underrun=%0b overflow=%0b, want %0d %0b %0b",
                 $time, lvl, uf, of, s.lvl, s.uf, s.of);
      end
      if (s.z) begin
        vectors++;
        if (ol !== 16'h0 || orr !== 16'h0) begin
          miscompares++;
          $display("FAIL muted @%0t: out=%h/%h, want 0000/0000", $time, ol, orr);
        end
      end
    end
    if (req_d) begin
      vectors++;
      if (data_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop @%0t: out=%h/%h, no expected entry queued", $time, ol, orr);
      end else begin
        p = data_q.pop_front();
        if (ol !== p.l || orr !== p.r) begin
          miscompares++;
          $display("FAIL pop @%0t: out=%h/%h, want %h/%h", $time, ol, orr, p.l, p.r);
        end
      end
    end
  end

  task automatic step(input bit r, input bit e, input bit vv, input logic [15:0] l,
                      input logic [15:0] rr, input bit q, input int el, input bit eu,
                      input bit eo, input bit ez);
    stat_t s;
    rst_n = r;
    en    = e;
    v     = vv;
    il    = l;
    ir    = rr;
    req   = q;
    @(posedge clk);
    s.lvl = el;
    s.uf  = eu;
    s.of  = eo;
    s.z   = ez;
    stat_q.push_back(s);
    #1;
    v   = 1'b0;
    req = 1'b0;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r, input int el, input bit eo);
    step(1'b1, 1'b1, 1'b1, l, r, 1'b0, el, 1'b0, eo, 1'b0);
  endtask

  task automatic pop(input logic [15:0] l, input logic [15:0] r, input int el, input bit eu);
    data_q.push_back({l, r});
    step(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b1, el, eu, 1'b0, 1'b0);
  endtask

  task automatic pushpop(input logic [15:0] pl, input logic [15:0] pr, input logic [15:0] el,
                         input logic [15:0] er, input int elv, input bit eu);
    data_q.push_back({el, er});
    step(1'b1, 1'b1, 1'b1, pl, pr, 1'b1, elv, eu, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    v     = 1'b0;
    req   = 1'b0;
    il    = '0;
    ir    = '0;

    // Reset held with enable high and pushes toggling.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, i[0], 16'hdead, 16'hbeef, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    end
    // IDLE -> PRIME; the push offered in IDLE is ignored.
    step(1'b1, 1'b1, 1'b1, 16'hdead, 16'hbeef, 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Priming: request after two pushes is answered with zeros and does not pop.
    push(16'h1111, 16'h2222, 1, 1'b0);
    push(16'h3333, 16'h4444, 2, 1'b0);
    pop(16'h0000, 16'h0000, 2, 1'b0);
    push(16'h5555, 16'h6666, 3, 1'b0);
    push(16'h7777, 16'h8888, 4, 1'b0);
    pop(16'h1111, 16'h2222, 3, 1'b0);

    // Fill to 8, then one dropped push.
    push(16'h8000, 16'hffff, 4, 1'b0);
    push(16'ha002, 16'hb002, 5, 1'b0);
    push(16'ha003, 16'hb003, 6, 1'b0);
    push(16'ha004, 16'hb004, 7, 1'b0);
    push(16'ha005, 16'hb005, 8, 1'b0);
    push(16'h0bad, 16'h0bad, 8, 1'b1);
    step(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 8, 1'b0, 1'b0, 1'b0);

    // Full with simultaneous push and pop: oldest comes out, no overflow.
    pushpop(16'hc001, 16'hd001, 16'h3333, 16'h4444, 8, 1'b0);

    // Drain; the dropped 0bad entry must never appear.
    pop(16'h5555, 16'h6666, 7, 1'b0);
    pop(16'h7777, 16'h8888, 6, 1'b0);
    pop(16'h8000, 16'hffff, 5, 1'b0);
    pop(16'ha002, 16'hb002, 4, 1'b0);
    pop(16'ha003, 16'hb003, 3, 1'b0);
    pop(16'ha004, 16'hb004, 2, 1'b0);
    pop(16'ha005, 16'hb005, 1, 1'b0);
    pop(16'hc001, 16'hd001, 0, 1'b0);

    // Underrun holds the last sample and drops back to PRIME.
    pop(16'hc001, 16'hd001, 0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    pop(16'h0000, 16'h0000, 0, 1'b0);

    // Re-prime, drain, then underrun with a coincident push that is stored.
    push(16'hc002, 16'hd002, 1, 1'b0);
    push(16'hc003, 16'hd003, 2, 1'b0);
    push(16'hc004, 16'hd004, 3, 1'b0);
    push(16'hc005, 16'hd005, 4, 1'b0);
    pop(16'hc002, 16'hd002, 3, 1'b0);
    pop(16'hc003, 16'hd003, 2, 1'b0);
    pop(16'hc004, 16'hd004, 1, 1'b0);
    pop(16'hc005, 16'hd005, 0, 1'b0);
    pushpop(16'hc006, 16'hd006, 16'hc005, 16'hd005, 1, 1'b1);

    // Back to RUN with level 5, then disable.
    push(16'hc007, 16'hd007, 2, 1'b0);
    push(16'hc008, 16'hd008, 3, 1'b0);
    push(16'hc009, 16'hd009, 4, 1'b0);
    push(16'hc00a, 16'hd00a, 5, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 16'h1234, 16'h5678, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Priming restarts from an empty FIFO.
    push(16'he001, 16'hf001, 1, 1'b0);
    pop(16'h0000, 16'h0000, 1, 1'b0);
    push(16'he002, 16'hf002, 2, 1'b0);
    push(16'he003, 16'hf003, 3, 1'b0);
    push(16'he004, 16'hf004, 4, 1'b0);
    pop(16'he001, 16'hf001, 3, 1'b0);

    // Reset mid-run clears everything regardless of enable.
    step(1'b0, 1'b1, 1'b1, 16'h9999, 16'h9999, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 0, 1'b0, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (data_q.size() != 0 || stat_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d pops and %0d status checks left, want 0 and 0",
               data_q.size(), stat_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
